// File: rtl/board_write_sched_if.sv
// Request handshake from the command decoder and the RAM write port of the
// board write scheduler, bundled into one interface.
interface board_write_sched_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
);
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    modport master (
        output req_we, req_addr, req_data,
        input  req_ready, we, waddr, wdata
    );

    modport slave (
        input  req_we, req_addr, req_data,
        output req_ready, we, waddr, wdata
    );
endinterface

// File: rtl/board_write_sched.sv
// Buffers board-cell write requests and commits them to the board RAM only
// during VGA blanking; also runs a full-board clear sequence.
module board_write_sched #(
    parameter int unsigned   AW        = 10,
    parameter int unsigned   DW        = 8,
    parameter int unsigned   DEPTH     = 8,
    parameter int unsigned   CELLS     = 600,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               resetB,
    board_write_sched_if.slave bus,
    input  logic               clear_req,
    input  logic               blank,
    output logic               busy,
    output logic               clear_done,
    output logic               overflow
);
    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = PW + 1;
    localparam int unsigned   EW       = AW + DW;
    localparam logic [AW-1:0] LAST     = AW'(CELLS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          clear_done_q, clear_done_d;
    logic          overflow_q, overflow_d;

    logic          full, empty, req_ready, push, pop, start_clear;
    logic [EW-1:0] head;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = ~full & (state_q != CLEAR);
    assign push      = bus.req_we & req_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        clear_done_d = 1'b0;
        overflow_d   = overflow_q;
        pop          = 1'b0;
        start_clear  = 1'b0;

        if (bus.req_we && !req_ready) overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                // Leave for DRAIN on the push itself so the first pop can
                // happen the very next cycle.
                if (clear_req) start_clear = 1'b1;
                else if (!empty || push) state_d = DRAIN;
            end
            DRAIN: begin
                if (clear_req) begin
                    start_clear = 1'b1;
                end else if (blank && !empty) begin
                    pop     = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = head[EW-1:DW];
                    wdata_d = head[DW-1:0];
                end
            end
            CLEAR: begin
                if (blank) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = CLEAR_VAL;
                    if (cnt_q == LAST) begin
                        clear_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (state_q == DRAIN && count_d == '0) state_d = IDLE;

        // Queued writes are stale once a clear starts; a same-cycle push is discarded too.
        if (start_clear) begin
            state_d    = CLEAR;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.req_addr, bus.req_data};
    end

    assign bus.req_ready = req_ready;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign busy          = (state_q != IDLE) | ~empty;
    assign clear_done    = clear_done_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_board_write_sched.sv
// Directed bench for board_write_sched: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_board_write_sched;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CELLS = 600;
    localparam logic [7:0]  CVAL  = 8'h00;

    logic clk = 1'b0;
    logic resetB = 1'b0;
    logic clear_req = 1'b0;
    logic blank = 1'b0;
    logic busy, clear_done, overflow;

    board_write_sched_if #(.AW(AW), .DW(DW)) bus ();

    board_write_sched #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .CELLS(CELLS), .CLEAR_VAL(CVAL)
    ) dut (
        .clk(clk), .resetB(resetB), .bus(bus),
        .clear_req(clear_req), .blank(blank),
        .busy(busy), .clear_done(clear_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus a clear cursor.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          mq[$];
    ent_t          m_e;
    bit            m_clr = 1'b0;
    bit            m_ready;
    int            m_next = 0;
    logic          e_we = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
    logic [AW-1:0] e_waddr = '0;
    logic [DW-1:0] e_wdata = '0;

    always @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            mq.delete();
            m_clr = 1'b0; m_next = 0;
            e_we = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
            e_waddr = '0; e_wdata = '0;
        end else begin
            m_ready = (mq.size() < DEPTH) && !m_clr;
            e_we = 1'b0;
            e_done = 1'b0;
            if (bus.req_we && !m_ready) e_ovf = 1'b1;
            if (m_clr) begin
                if (blank) begin
                    e_we = 1'b1; e_waddr = AW'(m_next); e_wdata = CVAL;
                    if (m_next == CELLS - 1) begin
                        e_done = 1'b1; m_clr = 1'b0;
                    end else m_next++;
                end
            end else if (clear_req) begin
                m_clr = 1'b1; m_next = 0; mq.delete(); e_ovf = 1'b0;
            end else begin
                if (blank && mq.size() > 0) begin
                    m_e = mq.pop_front();
                    e_we = 1'b1; e_waddr = m_e.a; e_wdata = m_e.d;
                end
                if (bus.req_we && m_ready) mq.push_back({bus.req_addr, bus.req_data});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we", bus.we, e_we);
            chk("waddr", bus.waddr, e_waddr);
            chk("wdata", bus.wdata, e_wdata);
            chk("clear_done", clear_done, e_done);
            chk("overflow", overflow, e_ovf);
            chk("busy", busy, m_clr || mq.size() > 0);
            chk("req_ready", bus.req_ready, (mq.size() < DEPTH) && !m_clr);
        end
    end

    // Write log of what the DUT actually issued.
    int            cyc = 0;
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    int            log_c[$];
    int            done_cnt = 0;
    logic [AW-1:0] done_addr = '0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.we) begin
            log_a.push_back(bus.waddr);
            log_d.push_back(bus.wdata);
            log_c.push_back(cyc);
        end
        if (clear_done) begin
            done_cnt++;
            done_addr = bus.waddr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_a.delete(); log_d.delete(); log_c.delete();
        done_cnt = 0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_we = 1'b1; bus.req_addr = a; bus.req_data = d;
    endtask

    initial begin
        int errs;
        bit found;
        bus.req_we = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        repeat (3) tick();
        chk("rst_we", bus.we, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk_en = 1'b1;
        resetB = 1'b1;

        // Single request, minimum latency
        blank = 1'b1;
        tick();
        push(10'd5, 8'h03);
        tick();
        bus.req_we = 1'b0;
        chk("lat_n1_we", bus.we, 0);
        tick();
        chk("lat_n2_we", bus.we, 1);
        chk("lat_n2_waddr", bus.waddr, 5);
        chk("lat_n2_wdata", bus.wdata, 8'h03);
        tick();
        chk("lat_n3_we", bus.we, 0);
        chk("lat_busy_fall", busy, 0);
        chk("lat_ovf", overflow, 0);

        // Fill while not blanking, overflow on the ninth
        blank = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("full_ready", bus.req_ready, 0);
            push(AW'(100 + i), DW'(16 + i));
            tick();
        end
        bus.req_we = 1'b0;
        chk("full_ovf", overflow, 1);
        clr_log();
        blank = 1'b1;
        repeat (12) tick();
        chk("drain_count", log_a.size(), 8);
        errs = 0;
        foreach (log_a[i]) begin
            if (log_a[i] !== AW'(100 + i) || log_d[i] !== DW'(16 + i)) errs++;
            if (log_c[i] != log_c[0] + i) errs++;
        end
        chk("drain_order", errs, 0);

        // Clear with blank 10 on / 10 off, re-pulse and a refused request mid-clear
        clr_log();
        for (int c = 0; c < 1260; c++) begin
            blank = ((c / 10) % 2) == 0;
            clear_req = (c == 0) || (c == 50);
            bus.req_we = (c == 35);
            bus.req_addr = 10'd77;
            if (c == 40) chk("clear_ready", bus.req_ready, 0);
            tick();
        end
        clear_req = 1'b0; bus.req_we = 1'b0;
        chk("clear_count", log_a.size(), CELLS);
        errs = 0;
        foreach (log_a[i]) if (log_a[i] !== AW'(i) || log_d[i] !== 8'h00) errs++;
        chk("clear_order", errs, 0);
        chk("clear_done_cnt", done_cnt, 1);
        chk("clear_done_addr", done_addr, 599);
        chk("clear_refused_ovf", overflow, 1);

        // Queued requests discarded by a clear
        blank = 1'b0;
        clr_log();
        for (int i = 0; i < 3; i++) begin
            push(AW'(1000 + i), 8'hA0);
            tick();
        end
        bus.req_we = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("flush_ovf", overflow, 0);
        chk("flush_busy", busy, 1);
        blank = 1'b1;
        repeat (610) tick();
        chk("flush_count", log_a.size(), CELLS);
        chk("flush_first", (log_a.size() > 0) ? log_a[0] : 10'h3FF, 0);
        errs = 0;
        foreach (log_a[i]) if (log_a[i] >= 10'd1000) errs++;
        chk("flush_stale", errs, 0);

        // Simultaneous push/pop at 7 of 8
        blank = 1'b0;
        clr_log();
        for (int i = 0; i < 7; i++) begin
            push(AW'(200 + i), DW'(i));
            tick();
        end
        blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(AW'(210 + i), DW'(50 + i));
            tick();
            chk("pp_ready", bus.req_ready, 1);
        end
        bus.req_we = 1'b0;
        repeat (10) tick();
        chk("pp_count", log_a.size(), 10);
        errs = 0;
        foreach (log_a[i]) begin
            if (i < 7 && log_a[i] !== AW'(200 + i)) errs++;
            if (i >= 7 && log_a[i] !== AW'(203 + i)) errs++;
        end
        chk("pp_order", errs, 0);

        // Reset in the middle of a clear
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (bus.we && bus.waddr == 10'd200) found = 1'b1;
            else tick();
        end
        chk("reach_200", found, 1);
        resetB = 1'b0;
        #1;
        chk("arst_we", bus.we, 0);
        chk("arst_waddr", bus.waddr, 0);
        chk("arst_busy", busy, 0);
        repeat (2) tick();
        clr_log();
        resetB = 1'b1;
        repeat (20) tick();
        chk("post_rst_writes", log_a.size(), 0);
        chk("post_rst_busy", busy, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
